// File: rtl/task_sequencer_pkg.sv
// rtl/task_sequencer_pkg.sv - shared widths, state encoding and memory map for the task sequencer
package task_sequencer_pkg;

  localparam int TS_WORD_WIDTH = 16;
  localparam int TS_ADDR_WIDTH = 11;
  localparam int TS_IDX_WIDTH  = 3;
  localparam int TS_CNT_WIDTH  = 10;

  // Fixed data-memory locations shared with the client blocks
  localparam logic [TS_ADDR_WIDTH-1:0] FLAG_ADDR = 11'h000;
  localparam logic [TS_ADDR_WIDTH-1:0] AGG_ADDR  = 11'h002;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EN     = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_e;

endpackage

// File: rtl/task_sequencer_bus_mux.sv
// rtl/task_sequencer_bus_mux.sv - gated combinational select of one client's memory bus slice
module task_bus_mux
  import task_sequencer_pkg::*;
#(
  parameter int NUM_TASKS  = 4,
  parameter int ADDR_WIDTH = TS_ADDR_WIDTH,
  parameter int WORD_WIDTH = TS_WORD_WIDTH
) (
  input  logic [TS_IDX_WIDTH-1:0]         sel,
  input  logic                            gate,
  input  logic [NUM_TASKS*ADDR_WIDTH-1:0] task_addr,
  input  logic [NUM_TASKS-1:0]            task_wr_en,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_wdata,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_wdata
);

  always_comb begin
    mem_address = '0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (gate && (sel == TS_IDX_WIDTH'(i))) begin
        mem_address = task_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wr_en   = task_wr_en[i];
        mem_wdata   = task_wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: rtl/task_sequencer.sv
// rtl/task_sequencer.sv - fires client tasks in index order via en/start/done and owns the data-memory bus
module task_sequencer
  import task_sequencer_pkg::*;
#(
  parameter int NUM_TASKS  = 4,
  parameter int WORD_WIDTH = TS_WORD_WIDTH,
  parameter int ADDR_WIDTH = TS_ADDR_WIDTH,
  parameter int TIMEOUT    = 1023
) (
  input  logic                            clock,
  input  logic                            nrst,
  input  logic                            go,
  input  logic [NUM_TASKS-1:0]            task_mask,
  output logic [NUM_TASKS-1:0]            task_en,
  output logic [NUM_TASKS-1:0]            task_start,
  input  logic [NUM_TASKS-1:0]            task_done,
  input  logic [NUM_TASKS*ADDR_WIDTH-1:0] task_addr,
  input  logic [NUM_TASKS-1:0]            task_wr_en,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_wdata,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_wdata,
  output logic                            busy,
  output logic [TS_IDX_WIDTH-1:0]         cur_task,
  output logic                            seq_done,
  output logic                            timeout_err
);

  localparam logic [TS_CNT_WIDTH-1:0] TIMEOUT_CNT = TS_CNT_WIDTH'(TIMEOUT);

  seq_state_e              state, state_nxt;
  logic [TS_IDX_WIDTH-1:0] idx, idx_nxt;
  logic [NUM_TASKS-1:0]    mask_q, mask_nxt;
  logic [TS_CNT_WIDTH-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
  logic                    timeout_nxt;
  logic [NUM_TASKS-1:0]    sel_onehot;
  logic [TS_IDX_WIDTH-1:0] first_idx, next_idx;
  logic                    next_found, done_sel, bus_gate;

  // Descending scan so the lowest qualifying index is the last one written
  always_comb begin
    sel_onehot = '0;
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      sel_onehot[i] = (idx == TS_IDX_WIDTH'(i));
      if (task_mask[i]) first_idx = TS_IDX_WIDTH'(i);
      if (mask_q[i] && (TS_IDX_WIDTH'(i) > idx)) begin
        next_idx   = TS_IDX_WIDTH'(i);
        next_found = 1'b1;
      end
    end
  end

  assign done_sel = |(task_done & sel_onehot);
  assign wait_inc = wait_cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    mask_nxt     = mask_q;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = timeout_err;
    task_en      = '0;
    task_start   = '0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          mask_nxt    = task_mask;
          timeout_nxt = 1'b0;
          idx_nxt     = first_idx;
          state_nxt   = (task_mask == '0) ? ST_FINISH : ST_EN;
        end
      end
      ST_EN: begin
        task_en   = sel_onehot;
        state_nxt = ST_START;
      end
      ST_START: begin
        task_start   = sel_onehot;
        wait_cnt_nxt = '0;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        // Abort on the TIMEOUT-th WAIT cycle without done; done in that cycle still wins
        if (done_sel) begin
          state_nxt = ST_NEXT;
        end else if (wait_inc == TIMEOUT_CNT) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_FINISH;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
      end
      ST_NEXT: begin
        if (next_found) begin
          idx_nxt   = next_idx;
          state_nxt = ST_EN;
        end else begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (!go) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      mask_q      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      mask_q      <= mask_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign seq_done = (state == ST_FINISH);
  assign cur_task = busy ? idx : '0;
  assign bus_gate = (state == ST_EN) || (state == ST_START) || (state == ST_WAIT);

  task_bus_mux #(
    .NUM_TASKS (NUM_TASKS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_bus_mux (
    .sel        (idx),
    .gate       (bus_gate),
    .task_addr  (task_addr),
    .task_wr_en (task_wr_en),
    .task_wdata (task_wdata),
    .mem_address(mem_address),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata)
  );

endmodule

// File: tb/tb_task_sequencer.sv
// tb/tb_task_sequencer.sv - directed self-checking bench for task_sequencer with stub clients and memory
`timescale 1ns/1ps
module tb_task_sequencer;
  import task_sequencer_pkg::*;

  localparam int NT = 4;
  localparam int AW = 11;
  localparam int WW = 16;
  localparam int TO = 15;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  logic go    = 1'b0;
  logic [NT-1:0]    task_mask = '0;
  logic [NT-1:0]    task_en, task_start, task_done;
  logic [NT*AW-1:0] task_addr;
  logic [NT-1:0]    task_wr_en;
  logic [NT*WW-1:0] task_wdata;
  logic [AW-1:0]    mem_address;
  logic             mem_wr_en;
  logic [WW-1:0]    mem_wdata;
  logic             busy, seq_done, timeout_err;
  logic [2:0]       cur_task;

  task_sequencer #(.NUM_TASKS(NT), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .nrst(nrst), .go(go), .task_mask(task_mask),
    .task_en(task_en), .task_start(task_start), .task_done(task_done),
    .task_addr(task_addr), .task_wr_en(task_wr_en), .task_wdata(task_wdata),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .busy(busy), .cur_task(cur_task), .seq_done(seq_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Single-port memory with combinational read
  logic [WW-1:0] mem [0:2047];
  logic [WW-1:0] mem_rdata;
  assign mem_rdata = mem[mem_address];
  always @(posedge clock) begin
    if (!nrst) begin
      mem[FLAG_ADDR] <= 16'd1;
      mem[AGG_ADDR]  <= 16'd0;
    end else if (mem_wr_en) begin
      mem[mem_address] <= mem_wdata;
    end
  end

  // Stub clients: done drops after en, rises delay[i] cycles after start (0 = never)
  int        delay [NT];
  logic      sink0 = 1'b0;
  logic      stray_wr1 = 1'b0;
  logic [NT-1:0] done_r, running;
  int        ccnt [NT];
  logic      flag_q;
  assign task_done = done_r;

  always @(posedge clock) begin
    if (!nrst) begin
      for (int i = 0; i < NT; i++) begin
        done_r[i]  <= 1'b0;
        running[i] <= 1'b0;
        ccnt[i]    <= 0;
      end
      flag_q <= 1'b0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (task_en[i]) done_r[i] <= 1'b0;
        if (task_start[i]) begin
          running[i] <= 1'b1;
          ccnt[i]    <= 1;
        end else if (running[i]) begin
          ccnt[i] <= ccnt[i] + 1;
          if (delay[i] != 0 && ccnt[i] == delay[i]) begin
            done_r[i]  <= 1'b1;
            running[i] <= 1'b0;
          end
        end
      end
      if (running[0] && ccnt[0] == 1) flag_q <= (mem_rdata == 16'd1);
    end
  end

  always_comb begin
    task_addr  = '0;
    task_wr_en = '0;
    task_wdata = '0;
    for (int i = 0; i < NT; i++) task_addr[i*AW +: AW] = 11'h010 + 11'(i);
    task_addr[0 +: AW]  = (running[0] && ccnt[0] == 2) ? AGG_ADDR : FLAG_ADDR;
    task_wr_en[0]       = sink0 && running[0] && (ccnt[0] == 2) && flag_q;
    task_wdata[0 +: WW] = 16'd1;
    task_wr_en[1]       = stray_wr1;
    task_wdata[WW +: WW] = 16'hBEEF;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int oh_idx(input logic [NT-1:0] v);
    int r = -1;
    for (int i = 0; i < NT; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Event log sampled on the falling edge
  int   en_idx[$], en_cyc[$], st_idx[$], st_cyc[$], st_cur[$];
  int   sd_cyc, to_cyc, own1_addr, own1_data, go_cyc;
  logic sd_prev = 1'b0, to_prev = 1'b0, own0_wr;

  always @(negedge clock) begin
    if (task_en != '0 || task_start != '0)
      check("pulse_onehot", int'($onehot({task_en, task_start})), 1);
    if (task_en != '0) begin
      en_idx.push_back(oh_idx(task_en));
      en_cyc.push_back(cyc);
    end
    if (task_start != '0) begin
      st_idx.push_back(oh_idx(task_start));
      st_cyc.push_back(cyc);
      st_cur.push_back(int'(cur_task));
    end
    if (seq_done && !sd_prev) sd_cyc = cyc;
    if (timeout_err && !to_prev) to_cyc = cyc;
    sd_prev = seq_done;
    to_prev = timeout_err;
    if (mem_wr_en && busy && cur_task == 3'd0) own0_wr = 1'b1;
    if (mem_wr_en && cur_task == 3'd1) begin
      own1_addr = int'(mem_address);
      own1_data = int'(mem_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    en_idx.delete(); en_cyc.delete();
    st_idx.delete(); st_cyc.delete(); st_cur.delete();
    sd_cyc = -1; to_cyc = -1; own1_addr = -1; own1_data = -1; own0_wr = 1'b0;
  endtask

  task automatic start_seq(input logic [NT-1:0] m);
    clear_logs();
    task_mask = m;
    go        = 1'b1;
    go_cyc    = cyc;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!seq_done && k < 400) begin
      tick(1);
      k++;
    end
    check({tag, "_finished"}, int'(seq_done), 1);
    tick(1);
  endtask

  task automatic end_seq(input string tag);
    go = 1'b0;
    tick(1);
    check({tag, "_seq_done_clr"}, int'(seq_done), 0);
    check({tag, "_busy_clr"}, int'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < NT; i++) delay[i] = 3;
    clear_logs();
    nrst = 1'b0;
    tick(3);
    check("rst_busy", int'(busy), 0);
    check("rst_seq_done", int'(seq_done), 0);
    check("rst_timeout", int'(timeout_err), 0);
    check("rst_cur_task", int'(cur_task), 0);
    check("rst_en_start", int'({task_en, task_start}), 0);
    check("rst_mem_wr", int'(mem_wr_en), 0);
    nrst = 1'b1;
    tick(1);

    // Single sink-flag client
    sink0 = 1'b1;
    start_seq(4'b0001);
    wait_done("t1");
    check("t1_en_count", en_idx.size(), 1);
    check("t1_en_idx", en_idx[0], 0);
    check("t1_en_lat", en_cyc[0] - go_cyc, 1);
    check("t1_start_lat", st_cyc[0] - go_cyc, 2);
    check("t1_done_lat", sd_cyc - go_cyc, 8);
    check("t1_mem_agg", int'(mem[AGG_ADDR]), 1);
    check("t1_timeout", int'(timeout_err), 0);
    check("t1_busy_finish", int'(busy), 1);
    end_seq("t1");
    sink0 = 1'b0;

    // Sparse mask: only tasks 1 and 3
    start_seq(4'b1010);
    wait_done("t2");
    check("t2_en_count", en_idx.size(), 2);
    check("t2_en0_idx", en_idx[0], 1);
    check("t2_en1_idx", en_idx[1], 3);
    check("t2_en1_cyc", en_cyc[1] - go_cyc, 8);
    check("t2_cur0", st_cur[0], 1);
    check("t2_cur1", st_cur[1], 3);
    check("t2_done_lat", sd_cyc - go_cyc, 15);
    end_seq("t2");

    // Task 2 hangs: abort after TIMEOUT wait cycles, task 3 skipped
    delay[2] = 0;
    start_seq(4'b1111);
    wait_done("t3");
    check("t3_en_count", en_idx.size(), 3);
    check("t3_st2_cyc", st_cyc[2] - go_cyc, 16);
    check("t3_to_after_start", to_cyc - st_cyc[2], 16);
    check("t3_timeout", int'(timeout_err), 1);
    check("t3_done_with_to", sd_cyc - to_cyc, 0);
    end_seq("t3");
    check("t3_timeout_sticky", int'(timeout_err), 1);
    delay[2] = 3;

    // Stale done from prior runs, stray write from a non-owner
    delay[0]  = 5;
    stray_wr1 = 1'b1;
    tick(1);
    check("t4_idle_wr_gated", int'(mem_wr_en), 0);
    start_seq(4'b0011);
    tick(1);
    check("t4_timeout_cleared", int'(timeout_err), 0);
    wait_done("t4");
    check("t4_en_count", en_idx.size(), 2);
    check("t4_wait_len", en_cyc[1] - st_cyc[0], 8);
    check("t4_own0_wr", int'(own0_wr), 0);
    check("t4_own1_addr", own1_addr, 17);
    check("t4_own1_data", own1_data, 16'hBEEF);
    check("t4_finish_wr_gated", int'(mem_wr_en), 0);
    check("t4_done_lat", sd_cyc - go_cyc, 17);
    end_seq("t4");
    stray_wr1 = 1'b0;
    delay[0]  = 3;

    // Reset during WAIT of task 1
    delay[1] = 0;
    start_seq(4'b0011);
    tick(12);
    check("t5_pre_cur", int'(cur_task), 1);
    nrst = 1'b0;
    go   = 1'b0;
    tick(1);
    check("t5_busy", int'(busy), 0);
    check("t5_cur", int'(cur_task), 0);
    check("t5_pulses", int'({task_en, task_start}), 0);
    check("t5_flags", int'({seq_done, timeout_err, mem_wr_en}), 0);
    clear_logs();
    nrst = 1'b1;
    tick(3);
    check("t5_no_repulse", en_idx.size() + st_idx.size(), 0);
    delay[1] = 3;
    start_seq(4'b0011);
    wait_done("t5");
    check("t5_restart_idx", en_idx[0], 0);
    check("t5_restart_lat", en_cyc[0] - go_cyc, 1);
    check("t5_restart_count", en_idx.size(), 2);
    check("t5_done_lat", sd_cyc - go_cyc, 15);
    end_seq("t5");

    // Empty mask
    start_seq(4'b0000);
    tick(1);
    check("t6_seq_done", int'(seq_done), 1);
    check("t6_busy", int'(busy), 1);
    tick(5);
    check("t6_hold", int'(seq_done), 1);
    check("t6_no_pulses", en_idx.size() + st_idx.size(), 0);
    check("t6_done_lat", sd_cyc - go_cyc, 1);
    end_seq("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
